// File: rtl/cas_pkg.sv
// Shared definitions for the CAS cassette path: recorder FSM states and the
// bit-timing constants also used by the loader's tape bit generator.
package cas_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEADER,
        DATA,
        FRAME,
        DONE,
        UPLOAD
    } cas_state_e;

    localparam int unsigned CAS_THRESH     = 48;
    localparam int unsigned CAS_MIN_PER    = 8;
    localparam int unsigned CAS_LEADER_MIN = 64;
    localparam int unsigned CAS_IDLE_TO    = 4096;

    // True when the state is one of the three that are actively capturing tape.
    function automatic logic is_capturing(input cas_state_e s);
        return (s == LEADER) || (s == DATA) || (s == FRAME);
    endfunction

endpackage

// File: rtl/cas_tape_recorder_if.sv
// hps_io ioctl upload handshake between the HPS side (master) and the
// tape recorder (slave).
interface cas_tape_recorder_if;

    logic        ioctl_upload_req;
    logic        ioctl_upload;
    logic        ioctl_rd;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_din;

    modport master (
        input  ioctl_upload_req,
        input  ioctl_din,
        output ioctl_upload,
        output ioctl_rd,
        output ioctl_addr
    );

    modport slave (
        output ioctl_upload_req,
        output ioctl_din,
        input  ioctl_upload,
        input  ioctl_rd,
        input  ioctl_addr
    );

endinterface

// File: rtl/cas_tape_recorder_period_decoder.sv
// Cassette-out front end: synchronizer, rising-edge detect, period counter,
// glitch filter and period-to-bit threshold.
module cas_period_decoder
    import cas_pkg::*;
#(
    parameter int unsigned THRESH  = CAS_THRESH,
    parameter int unsigned MIN_PER = CAS_MIN_PER,
    parameter int unsigned IDLE_TO = CAS_IDLE_TO
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic clk_en_i,
    input  logic tape_i,
    output logic bit_valid_o,
    output logic bit_val_o,
    output logic timeout_o
);

    localparam int unsigned CW = $clog2(IDLE_TO + 1);

    logic [1:0]    sync_q;
    logic          prev_q;
    logic [CW-1:0] count_q, count_d;
    logic          rise;
    logic          accept;

    assign rise   = sync_q[1] & ~prev_q;
    // Short periods leave the counter running so the next genuine edge still
    // measures from the last accepted one.
    assign accept = rise && (count_q >= CW'(MIN_PER));

    always_comb begin
        count_d = count_q;
        if (accept) begin
            count_d = '0;
        end else if (clk_en_i && (count_q != CW'(IDLE_TO))) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            count_q <= '0;
        end else begin
            sync_q  <= {sync_q[0], tape_i};
            prev_q  <= sync_q[1];
            count_q <= count_d;
        end
    end

    assign bit_valid_o = accept;
    assign bit_val_o   = (count_q < CW'(THRESH));
    assign timeout_o   = (count_q == CW'(IDLE_TO)) && !accept;

endmodule

// File: rtl/cas_tape_recorder.sv
// Captures the M5 cassette-out stream during BASIC SAVE, frames it into bytes
// in an on-chip buffer and serves the buffer through the hps_io upload port.
module cas_tape_recorder
    import cas_pkg::*;
#(
    parameter int unsigned BUF_AW     = 15,
    parameter int unsigned THRESH     = CAS_THRESH,
    parameter int unsigned MIN_PER    = CAS_MIN_PER,
    parameter int unsigned LEADER_MIN = CAS_LEADER_MIN,
    parameter int unsigned IDLE_TO    = CAS_IDLE_TO
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              clk_en_i,
    input  logic              tape_out_i,
    cas_tape_recorder_if.slave ioctl,
    output logic [BUF_AW:0]   rec_len_o,
    output logic              recording_o,
    output logic              overflow_o
);

    localparam int unsigned LW = $clog2(LEADER_MIN + 1);

    logic bit_valid;
    logic bit_val;
    logic timeout;

    cas_period_decoder #(
        .THRESH  (THRESH),
        .MIN_PER (MIN_PER),
        .IDLE_TO (IDLE_TO)
    ) u_decoder (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .clk_en_i    (clk_en_i),
        .tape_i      (tape_out_i),
        .bit_valid_o (bit_valid),
        .bit_val_o   (bit_val),
        .timeout_o   (timeout)
    );

    cas_state_e      state_q, state_d;
    logic [LW-1:0]   leader_q, leader_d;
    logic [3:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [BUF_AW:0] wr_ptr_q, wr_ptr_d;
    logic [BUF_AW:0] rec_len_q, rec_len_d;
    logic            overflow_q, overflow_d;
    logic            req_q, req_d;
    logic            upl_prev_q;
    logic            upl_fall;
    logic            we;

    assign upl_fall = upl_prev_q & ~ioctl.ioctl_upload;

    always_comb begin
        state_d    = state_q;
        leader_d   = leader_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        wr_ptr_d   = wr_ptr_q;
        rec_len_d  = wr_ptr_q;
        overflow_d = overflow_q;
        req_d      = 1'b0;
        we         = 1'b0;
        case (state_q)
            IDLE: begin
                if (bit_valid) begin
                    state_d    = LEADER;
                    leader_d   = '0;
                    overflow_d = 1'b0;
                end
            end
            LEADER: begin
                if (bit_valid) begin
                    if (bit_val) begin
                        if (leader_q != LW'(LEADER_MIN)) leader_d = leader_q + 1'b1;
                    end else if (leader_q >= LW'(LEADER_MIN)) begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end else begin
                        leader_d = '0;
                    end
                end else if (timeout) begin
                    state_d = DONE;
                end
            end
            DATA: begin
                if (bit_valid) begin
                    if (bit_idx_q < 4'd8) begin
                        shift_d   = {bit_val, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 1'b1;
                    end else if (bit_val) begin
                        // Top pointer bit set means all 2^BUF_AW slots are used.
                        if (wr_ptr_q[BUF_AW]) begin
                            overflow_d = 1'b1;
                        end else begin
                            we       = 1'b1;
                            wr_ptr_d = wr_ptr_q + 1'b1;
                        end
                        state_d = FRAME;
                    end else begin
                        state_d  = LEADER;
                        leader_d = '0;
                    end
                end else if (timeout) begin
                    state_d = DONE;
                end
            end
            FRAME: begin
                if (bit_valid) begin
                    if (!bit_val) begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end
                end else if (timeout) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (rec_len_q == '0) begin
                    state_d = IDLE;
                end else begin
                    req_d   = 1'b1;
                    state_d = UPLOAD;
                end
            end
            UPLOAD: begin
                if (upl_fall) begin
                    state_d   = IDLE;
                    wr_ptr_d  = '0;
                    rec_len_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= IDLE;
            leader_q   <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            wr_ptr_q   <= '0;
            rec_len_q  <= '0;
            overflow_q <= 1'b0;
            req_q      <= 1'b0;
            upl_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            leader_q   <= leader_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            wr_ptr_q   <= wr_ptr_d;
            rec_len_q  <= rec_len_d;
            overflow_q <= overflow_d;
            req_q      <= req_d;
            upl_prev_q <= ioctl.ioctl_upload;
        end
    end

    logic [7:0] mem [0:(1 << BUF_AW) - 1];
    logic [7:0] ram_rd_q;
    logic       in_range_q;

    always_ff @(posedge clk_i) begin
        if (we) mem[wr_ptr_q[BUF_AW-1:0]] <= shift_q;
        if (ioctl.ioctl_rd) ram_rd_q <= mem[ioctl.ioctl_addr[BUF_AW-1:0]];
    end

    // Range flag is kept apart from the RAM read so the array stays reset-free.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            in_range_q <= 1'b0;
        end else if (ioctl.ioctl_rd) begin
            in_range_q <= (ioctl.ioctl_addr < 25'(rec_len_q));
        end
    end

    assign ioctl.ioctl_din        = in_range_q ? ram_rd_q : 8'h00;
    assign ioctl.ioctl_upload_req = req_q;
    assign rec_len_o              = rec_len_q;
    assign recording_o            = is_capturing(state_q);
    assign overflow_o             = overflow_q;

endmodule

// File: tb/tb_cas_tape_recorder.sv
// Bench for cas_tape_recorder: a full-size and a 4-byte-buffer instance share
// one tape stream; expected bytes come from a queue of what was sent.
module tb_cas_tape_recorder;
    import cas_pkg::*;

    localparam int unsigned TO = 4096;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic clk_en = 1'b1;
    logic tape = 1'b0;

    cas_tape_recorder_if bus_a ();
    cas_tape_recorder_if bus_b ();

    logic [15:0] len_a;
    logic [2:0]  len_b;
    logic        rec_a, rec_b, ovf_a, ovf_b;

    cas_tape_recorder #(.BUF_AW(15)) dut_a (
        .clk_i       (clk),
        .reset_n_i   (reset_n),
        .clk_en_i    (clk_en),
        .tape_out_i  (tape),
        .ioctl       (bus_a),
        .rec_len_o   (len_a),
        .recording_o (rec_a),
        .overflow_o  (ovf_a)
    );

    cas_tape_recorder #(.BUF_AW(2)) dut_b (
        .clk_i       (clk),
        .reset_n_i   (reset_n),
        .clk_en_i    (clk_en),
        .tape_out_i  (tape),
        .ioctl       (bus_b),
        .rec_len_o   (len_b),
        .recording_o (rec_b),
        .overflow_o  (ovf_b)
    );

    always #5 clk = ~clk;

    int unsigned req_a = 0;
    int unsigned req_b = 0;
    always @(posedge clk) begin
        if (bus_a.ioctl_upload_req) req_a++;
        if (bus_b.ioctl_upload_req) req_b++;
    end

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [7:0]  exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned small_len();
        return (exp_q.size() > 4) ? 4 : exp_q.size();
    endfunction

    // One tape period of p clocks, starting just after a rise and ending on the next rise.
    task automatic period(input int unsigned p, input bit glitch);
        for (int unsigned k = 1; k <= p; k++) begin
            @(negedge clk);
            tape = (k == p) || (k < 2) || (glitch && (k == 4 || k == 5));
        end
    endtask

    task automatic send_bit(input bit b, input bit glitch);
        period(b ? $urandom_range(40, 12) : $urandom_range(90, 56), glitch);
    endtask

    task automatic start_edge();
        @(negedge clk); tape = 1'b0;
        repeat (3) @(negedge clk);
        tape = 1'b1;
    endtask

    task automatic leader(input int unsigned n, input bit fixed);
        for (int unsigned i = 0; i < n; i++) begin
            if (fixed) period(33, 1'b0);
            else send_bit(1'b1, 1'b0);
        end
    endtask

    task automatic send_byte(input logic [7:0] v, input bit stop, input bit glitch);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(v[i], glitch);
        send_bit(stop, 1'b0);
    endtask

    task automatic silence(input int unsigned exp_req);
        int unsigned a0, b0;
        a0 = req_a;
        b0 = req_b;
        @(negedge clk); tape = 1'b0;
        repeat (TO + 40) @(negedge clk);
        check("upload_req_pulses_a", req_a - a0, exp_req);
        check("upload_req_pulses_b", req_b - b0, exp_req);
    endtask

    task automatic do_read(input logic [24:0] addr);
        logic [7:0] ea, eb;
        ea = (addr < exp_q.size()) ? exp_q[addr] : 8'h00;
        eb = (addr < small_len()) ? exp_q[addr] : 8'h00;
        @(negedge clk);
        bus_a.ioctl_rd = 1'b1; bus_a.ioctl_addr = addr;
        bus_b.ioctl_rd = 1'b1; bus_b.ioctl_addr = addr;
        @(negedge clk);
        bus_a.ioctl_rd = 1'b0; bus_b.ioctl_rd = 1'b0;
        bus_a.ioctl_addr = 25'h1ff_ffff; bus_b.ioctl_addr = 25'h1ff_ffff;
        check($sformatf("din_a@%0d", addr), bus_a.ioctl_din, ea);
        check($sformatf("din_b@%0d", addr), bus_b.ioctl_din, eb);
    endtask

    task automatic upload_and_read(input int unsigned last_addr);
        check("len_a", len_a, exp_q.size());
        check("len_b", len_b, small_len());
        check("ovf_a", ovf_a, 1'b0);
        check("ovf_b", ovf_b, exp_q.size() > 4);
        check("rec_a_upload", rec_a, 1'b0);
        @(negedge clk);
        bus_a.ioctl_upload = 1'b1; bus_b.ioctl_upload = 1'b1;
        for (int unsigned a = 0; a <= last_addr; a++) do_read(25'(a));
        repeat (3) @(negedge clk);
        check("din_hold_a", bus_a.ioctl_din, (last_addr < exp_q.size()) ? exp_q[last_addr] : 8'h00);
        bus_a.ioctl_upload = 1'b0; bus_b.ioctl_upload = 1'b0;
        repeat (3) @(negedge clk);
        check("len_a_after_upload", len_a, 0);
        check("len_b_after_upload", len_b, 0);
        exp_q.delete();
        do_read(25'd0);
    endtask

    initial begin
        int unsigned n;
        logic [7:0]  v;
        bus_a.ioctl_upload = 1'b0; bus_a.ioctl_rd = 1'b0; bus_a.ioctl_addr = '0;
        bus_b.ioctl_upload = 1'b0; bus_b.ioctl_rd = 1'b0; bus_b.ioctl_addr = '0;

        repeat (3) @(negedge clk);
        check("reset_len_a", len_a, 0);
        check("reset_rec_a", rec_a, 1'b0);
        check("reset_ovf_b", ovf_b, 1'b0);
        check("reset_req_a", bus_a.ioctl_upload_req, 1'b0);
        check("reset_din_a", bus_a.ioctl_din, 8'h00);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);

        // Basic recording of 0xA5
        start_edge();
        leader(64, 1'b1);
        check("rec_a_leader", rec_a, 1'b1);
        send_byte(8'hA5, 1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        exp_q.push_back(8'hA5);
        silence(1);
        upload_and_read(1);

        // 63-period leader does not qualify
        start_edge();
        leader(63, 1'b1);
        send_bit(1'b0, 1'b0);
        repeat (8) @(negedge clk);
        check("short_leader_len", len_a, 0);
        leader(64, 1'b1);
        send_byte(8'h3C, 1'b1, 1'b0);
        exp_q.push_back(8'h3C);
        silence(1);
        upload_and_read(1);

        // Framing error discards the byte
        start_edge();
        leader(64, 1'b1);
        send_byte(8'h11, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        check("frame_err_len", len_a, 0);
        check("frame_err_rec", rec_a, 1'b1);
        silence(0);
        check("frame_err_idle_rec", rec_a, 1'b0);

        // Glitches inside data bits
        start_edge();
        leader(64, 1'b1);
        send_byte(8'h5A, 1'b1, 1'b1);
        exp_q.push_back(8'h5A);
        silence(1);
        upload_and_read(1);

        // Five bytes overflow the 4-byte instance
        start_edge();
        leader(64, 1'b1);
        for (int unsigned i = 1; i <= 5; i++) begin
            send_byte(8'(i), 1'b1, 1'b0);
            exp_q.push_back(8'(i));
            for (int unsigned g = $urandom_range(2, 0); g > 0; g--) send_bit(1'b1, 1'b0);
        end
        silence(1);
        check("ovf_b_set", ovf_b, 1'b1);
        upload_and_read(4);

        // Randomized block, overflow flag must clear on new leader
        start_edge();
        leader($urandom_range(80, 64), 1'b0);
        check("ovf_b_cleared", ovf_b, 1'b0);
        n = $urandom_range(7, 4);
        for (int unsigned i = 0; i < n; i++) begin
            v = 8'($urandom);
            if ($urandom_range(5, 0) == 0) begin
                send_byte(v, 1'b0, 1'($urandom));
                leader($urandom_range(70, 64), 1'b0);
            end else begin
                send_byte(v, 1'b1, 1'($urandom));
                exp_q.push_back(v);
                for (int unsigned g = $urandom_range(2, 0); g > 0; g--) send_bit(1'b1, 1'b0);
            end
        end
        send_bit(1'b1, 1'b0);
        silence((exp_q.size() != 0) ? 1 : 0);
        if (exp_q.size() != 0) upload_and_read(n);

        // Asynchronous reset in the middle of a byte
        start_edge();
        leader(64, 1'b1);
        send_byte(8'h77, 1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        @(negedge clk);
        check("pre_reset_rec", rec_a, 1'b1);
        check("pre_reset_len", len_a, 1);
        #3 reset_n = 1'b0;
        #1;
        check("async_reset_rec_a", rec_a, 1'b0);
        check("async_reset_rec_b", rec_b, 1'b0);
        check("async_reset_len_a", len_a, 0);
        check("async_reset_len_b", len_b, 0);
        tape = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
